// File: rtl/sass_r.sv
// sass_r: SASS serial-line receiver; recovers start/data/delimiter frames from s.
// Ports: clk, rst (async, active-high), s (async serial in, idle high),
//        data (last good word), valid (1-cycle strobe), frame_err (1-cycle strobe),
//        busy (receiver not idle).
module sass_r #(
  parameter int data_l = 8,
  parameter int clk_f  = 50_000_000,
  parameter int range  = 1_000_000,
  parameter int t      = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s,
  output logic [data_l-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);
  // 64-bit math: clk_f*t overflows 32 bits at default settings
  localparam longint TDL = longint'(clk_f) * longint'(t) / longint'(range);
  localparam int TD = int'(TDL);
  localparam int CW = $clog2(TD + 1);
  localparam int BW = $clog2(data_l + 1);
  localparam logic [CW-1:0] TD_C   = CW'(TD);
  localparam logic [CW-1:0] HALF_C = CW'(TD / 2);
  localparam logic [BW-1:0] LAST_C = BW'(data_l - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, DELIM = 3'd3, WAIT_IDLE = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bitc_q, bitc_d;
  logic [data_l-1:0] shift_q, shift_d, data_q, data_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic              s_meta_q, s_sync_q, s_prev_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitc_d  = bitc_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (s_prev_q && !s_sync_q) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        // mid-start-bit check rejects short glitches
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          bitc_d  = '0;
          state_d = s_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TD_C) begin
          cnt_d   = '0;
          bitc_d  = bitc_q + 1'b1;
          shift_d = {s_sync_q, shift_q[data_l-1:1]};
          state_d = (bitc_q == LAST_C) ? DELIM : DATA;
        end
      end
      DELIM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TD_C) begin
          cnt_d   = '0;
          state_d = WAIT_IDLE;
          valid_d = !s_sync_q;
          err_d   = s_sync_q;
          data_d  = s_sync_q ? data_q : shift_q;
        end
      end
      WAIT_IDLE: state_d = s_sync_q ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitc_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      s_meta_q <= 1'b1;
      s_sync_q <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitc_q   <= bitc_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      s_meta_q <= s;
      s_sync_q <= s_meta_q;
      s_prev_q <= s_sync_q;
    end
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: doc/sass_r.md
Name: sass_r

Overview:
- SASS receiver v1: the downstream stage of the SASS transmitter. It recovers frames from the single-wire line `s`.
- Line format: idle high, then a start bit (low), then `data_l` data bits LSB first, then one end-delimiter bit that must be 0, then the line returns high.
- Every bit lasts `t_d+1` clocks, where `t_d = clk_f*t/range`.
- Outputs the received word with a one-cycle valid strobe, or flags a framing error.

Parameters:
- `data_l`, 8, data bits per frame.
- `clk_f`, 50_000_000, clock frequency in Hz.
- `range`, 1_000_000, time-unit divisor.
- `t`, 300, bit duration in `range` units. `t_d = clk_f*t/range` (integer division); bit period is `t_d+1` clocks.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `s`  in  1  serial line, asynchronous to `clk`, idle high.
- `data`  out  `data_l`  last correctly framed word; holds until the next valid frame.
- `valid`  out  1  one-cycle pulse: `data` updated.
- `frame_err`  out  1  one-cycle pulse: delimiter sampled high.
- `busy`  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - `data=0`, `valid=0`, `frame_err=0`, `busy=0`.
  - `state=IDLE`; counters 0; shift register 0.
  - Synchroniser flops `s_meta`, `s_sync` and edge flop `s_prev` reset to 1 (idle).
- Sync: 2-flop synchroniser `s`->`s_meta`->`s_sync`. All decisions use `s_sync`. `s_prev` is `s_sync` delayed one clock.
- Counters and widths:
  - `cnt`: width `$clog2(t_d+1)`, counts 0..`t_d`.
  - `bitc`: width `$clog2(data_l+1)`.
  - `HALF = t_d/2` (integer).
- IDLE:
  - `s_prev==1 && s_sync==0` -> START, `cnt<=0`.
- START:
  - `cnt` increments each clock.
  - At `cnt==HALF`, sample `s_sync`:
    - 0 -> DATA, `cnt<=0`, `bitc<=0`.
    - 1 -> glitch, back to IDLE; no flags raised.
- DATA:
  - `cnt` increments.
  - At `cnt==t_d`: shift `s_sync` in at the MSB of the shift register (LSB-first reception), `cnt<=0`, `bitc<=bitc+1`.
  - When the `data_l`-th bit is taken (`bitc==data_l-1` at sample time) -> DELIM.
- DELIM:
  - At `cnt==t_d`, sample `s_sync`:
    - 0 -> `data<=shift`, `valid=1` the next cycle only.
    - 1 -> `frame_err=1` the next cycle only; `data` unchanged.
  - Either way -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `s_sync==1`, then -> IDLE.
  - No new start is accepted until the line has been high for at least one clock, because `s_prev` must be 1 for edge detection.
- Latency: let E be the clock edge at which `s_sync` is first 0.
  - START is entered at E+1.
  - Sample k (k=0 is the start check, k=1..`data_l` are data, k=`data_l+1` is the delimiter) occurs at E+1+HALF+k·(`t_d+1`).
  - `valid`/`frame_err` are high in the cycle after the delimiter sample.
- Mid-bit sampling tolerates up to ±HALF clocks of accumulated skew over the frame. The transmitter and receiver are built with identical parameters, so nominal skew is 0.
- Back-to-back frames:
  - The transmitter releases the line high for at least one bit period between frames.
  - The receiver must be in IDLE within 3 clocks of `s` rising.
- `valid` and `frame_err` are never high in the same cycle.
- `rst` mid-frame: immediate return to reset values; any partial frame is discarded and no pulse is emitted.
  - If `s` is low when `rst` releases, `s_prev=1` makes it look like a start. The frame either completes, errors, or parks in WAIT_IDLE until the line goes high; this is accepted behaviour.
- Degenerate `t_d==0`: not supported; the minimum legal `t_d` is 2.

Test Plan:
- Bench config: `clk_f=1_000_000`, `range=1_000_000`, `t=8`, so `t_d=8`, period 9 clocks, `HALF=4`. Drive `s` from a `sass_t` instance with identical parameters.
- Single frame: `sass_t` send `data=8'hA5` -> `valid` one cycle at E+1+4+9·9 = E+86 (+1 register stage); `data==8'hA5`; `frame_err` never high; `busy` falls within 3 clocks of `s` rising.
- Back-to-back: send `8'h00`, `8'hFF`, `8'h81` on consecutive `busy` falls -> three `valid` pulses with `data` 00, FF, 81 in order; no `frame_err`.
- Glitch: with the line idle, drive `s` low for 3 clocks -> START is entered then aborted at the HALF sample; state returns to IDLE; no `valid`/`frame_err`; `data` retains the previous value.
- Framing error: bench-driven frame start 0, `data 8'h3C` LSB first, delimiter 1 for 9 clocks, then idle -> `frame_err` pulses one cycle; `valid` stays 0; `data` unchanged; receiver back in IDLE.
- Reset mid-frame: assert `rst` during data bit 4 of `8'h5A` -> all outputs 0 immediately. After release, the next full frame `8'hC3` is received correctly. A stuck-low line after reset parks in WAIT_IDLE until high, with at most one `frame_err`/`valid` pulse.
